// File: rtl/kv_cache_pkg.sv
// rtl/kv_cache_pkg.sv - shared op/status/state types for the key-value cache engine
package kv_cache_pkg;

    localparam logic [1:0] FSM_IDLE   = 2'd0;
    localparam logic [1:0] FSM_LOOKUP = 2'd1;
    localparam logic [1:0] FSM_EXEC   = 2'd2;
    localparam logic [1:0] FSM_RESP   = 2'd3;

    typedef enum logic [1:0] {
        OP_GET   = 2'd0,
        OP_PUT   = 2'd1,
        OP_DEL   = 2'd2,
        OP_FLUSH = 2'd3
    } kv_op_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_MISS    = 2'd1,
        ST_FULL    = 2'd2,
        ST_EVICTED = 2'd3
    } kv_status_t;

    typedef enum logic [1:0] {
        S_IDLE   = FSM_IDLE,
        S_LOOKUP = FSM_LOOKUP,
        S_EXEC   = FSM_EXEC,
        S_RESP   = FSM_RESP
    } kv_state_t;

endpackage

// File: rtl/kv_entry_store.sv
// rtl/kv_entry_store.sv - fully associative key/value table with parallel match and free-slot search
// Ports:
//   clk, rst                      clock, asynchronous active-high reset (clears valid bits only)
//   lookup_key -> hit, hit_idx    parallel compare against all valid entries (match is one-hot)
//   free_idx, full                lowest invalid slot, all slots valid
//   rd_idx -> rd_key, rd_value    combinational read port
//   wr_en/wr_idx/wr_key/wr_value  write an entry and mark it valid
//   clr_en/clr_idx                invalidate one entry
//   flush                         invalidate every entry
module kv_entry_store #(
    parameter int NUM_ENTRIES = 16,
    parameter int KEY_WIDTH   = 16,
    parameter int VALUE_WIDTH = 64,
    localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [KEY_WIDTH-1:0]   lookup_key,
    output logic                   hit,
    output logic [IDX_W-1:0]       hit_idx,
    output logic [IDX_W-1:0]       free_idx,
    output logic                   full,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [KEY_WIDTH-1:0]   rd_key,
    output logic [VALUE_WIDTH-1:0] rd_value,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [KEY_WIDTH-1:0]   wr_key,
    input  logic [VALUE_WIDTH-1:0] wr_value,
    input  logic                   clr_en,
    input  logic [IDX_W-1:0]       clr_idx,
    input  logic                   flush
);

    logic [KEY_WIDTH-1:0]   keys   [NUM_ENTRIES];
    logic [VALUE_WIDTH-1:0] values [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] valid;
    logic [NUM_ENTRIES-1:0] match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else begin
            if (wr_en)  valid[wr_idx]  <= 1'b1;
            if (clr_en) valid[clr_idx] <= 1'b0;
        end
    end

    // Key/value storage carries no reset; only the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            keys[wr_idx]   <= wr_key;
            values[wr_idx] <= wr_value;
        end
    end

    always_comb begin
        match    = '0;
        hit_idx  = '0;
        free_idx = '0;
        // Match is one-hot by construction, so OR-ing indices is an exact encoder.
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            match[i] = valid[i] && (keys[i] == lookup_key);
            if (match[i]) hit_idx = hit_idx | IDX_W'(i);
        end
        // Descending scan leaves the lowest free index as the last assignment.
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) free_idx = IDX_W'(i);
        end
    end

    assign hit      = |match;
    assign full     = &valid;
    assign rd_key   = keys[rd_idx];
    assign rd_value = values[rd_idx];

endmodule

// File: rtl/kv_cache_engine.sv
// rtl/kv_cache_engine.sv - GET/PUT/DEL/FLUSH key-value cache engine with valid/ready handshakes
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   req_valid_i/req_ready_o         request handshake (ready only in IDLE)
//   req_op_i, req_key_i, req_value_i  op (GET=0 PUT=1 DEL=2 FLUSH=3), key, PUT data
//   resp_valid_o/resp_ready_i       response handshake, response held until taken
//   resp_status_o                   OK=0 MISS=1 FULL=2 EVICTED=3
//   resp_value_o                    GET hit data, else 0
//   resp_evict_key_o                displaced key on EVICTED, else 0
//   used_count_o                    number of valid entries
// Build option: KV_LRU_EVICT_EN enables per-entry ages and LRU replacement on a full-table PUT miss.
module kv_cache_engine
    import kv_cache_pkg::*;
#(
    parameter int NUM_ENTRIES  = 16,
    parameter int KEY_WIDTH    = 16,
    parameter int VALUE_WIDTH  = 64,
    localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [1:0]             req_op_i,
    input  logic [KEY_WIDTH-1:0]   req_key_i,
    input  logic [VALUE_WIDTH-1:0] req_value_i,
    output logic                   resp_valid_o,
    input  logic                   resp_ready_i,
    output logic [1:0]             resp_status_o,
    output logic [VALUE_WIDTH-1:0] resp_value_o,
    output logic [KEY_WIDTH-1:0]   resp_evict_key_o,
    output logic [IDX_W:0]         used_count_o
);

    kv_state_t state, state_nxt;

    kv_op_t                 op_q;
    logic [KEY_WIDTH-1:0]   key_q;
    logic [VALUE_WIDTH-1:0] value_q;
    logic                   hit_q, full_q;
    logic [IDX_W-1:0]       hit_idx_q, free_idx_q;

    logic                   st_hit, st_full;
    logic [IDX_W-1:0]       st_hit_idx, st_free_idx;
    logic [KEY_WIDTH-1:0]   rd_key;
    logic [VALUE_WIDTH-1:0] rd_value;

    logic                   exec;
    logic                   do_write, do_insert, do_evict, do_clear, do_flush;
    logic [IDX_W-1:0]       wr_idx, victim_idx, rd_idx;
    kv_status_t             status_nxt;

    kv_entry_store #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .KEY_WIDTH   (KEY_WIDTH),
        .VALUE_WIDTH (VALUE_WIDTH)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .lookup_key (key_q),
        .hit        (st_hit),
        .hit_idx    (st_hit_idx),
        .free_idx   (st_free_idx),
        .full       (st_full),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key),
        .rd_value   (rd_value),
        .wr_en      (do_write),
        .wr_idx     (wr_idx),
        .wr_key     (key_q),
        .wr_value   (value_q),
        .clr_en     (do_clear),
        .clr_idx    (hit_idx_q),
        .flush      (do_flush)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (req_valid_i) state_nxt = S_LOOKUP;
            S_LOOKUP: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = S_RESP;
            S_RESP:   if (resp_ready_i) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Reset forces ready low so every output reads 0 while rst is held.
    assign req_ready_o  = (state == S_IDLE) && !rst;
    assign resp_valid_o = (state == S_RESP);
    assign exec         = (state == S_EXEC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= OP_GET;
            key_q      <= '0;
            value_q    <= '0;
            hit_q      <= 1'b0;
            full_q     <= 1'b0;
            hit_idx_q  <= '0;
            free_idx_q <= '0;
        end else begin
            if (state == S_IDLE && req_valid_i) begin
                op_q    <= kv_op_t'(req_op_i);
                key_q   <= req_key_i;
                value_q <= req_value_i;
            end
            if (state == S_LOOKUP) begin
                hit_q      <= st_hit;
                full_q     <= st_full;
                hit_idx_q  <= st_hit_idx;
                free_idx_q <= st_free_idx;
            end
        end
    end

    // Table-update strobes are qualified by EXEC; status is only consumed there.
    always_comb begin
        do_write   = 1'b0;
        do_insert  = 1'b0;
        do_evict   = 1'b0;
        do_clear   = 1'b0;
        do_flush   = 1'b0;
        wr_idx     = hit_idx_q;
        status_nxt = ST_OK;
        case (op_q)
            OP_GET: if (!hit_q) status_nxt = ST_MISS;
            OP_PUT: begin
                if (hit_q) begin
                    do_write = exec;
                end else if (!full_q) begin
                    do_write  = exec;
                    do_insert = exec;
                    wr_idx    = free_idx_q;
                end else begin
`ifdef KV_LRU_EVICT_EN
                    do_write   = exec;
                    do_evict   = exec;
                    wr_idx     = victim_idx;
                    status_nxt = ST_EVICTED;
`else
                    status_nxt = ST_FULL;
`endif
                end
            end
            OP_DEL: begin
                if (hit_q) do_clear = exec;
                else       status_nxt = ST_MISS;
            end
            OP_FLUSH: do_flush = exec;
            default:  status_nxt = ST_OK;
        endcase
    end

    // The read port serves the GET hit value, or the victim key when replacing.
    assign rd_idx = do_evict ? victim_idx : hit_idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_status_o    <= '0;
            resp_value_o     <= '0;
            resp_evict_key_o <= '0;
        end else if (exec) begin
            resp_status_o    <= status_nxt;
            resp_value_o     <= (op_q == OP_GET && hit_q) ? rd_value : '0;
            resp_evict_key_o <= do_evict ? rd_key : '0;
        end
    end

    // Eviction swaps one entry for another, so it leaves the count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            used_count_o <= '0;
        else if (do_flush)  used_count_o <= '0;
        else if (do_insert) used_count_o <= used_count_o + (IDX_W + 1)'(1);
        else if (do_clear)  used_count_o <= used_count_o - (IDX_W + 1)'(1);
    end

`ifdef KV_LRU_EVICT_EN
    logic [IDX_W-1:0] age [NUM_ENTRIES];
    logic             touch;
    logic [IDX_W:0]   old_age;

    // Oldest entry wins; strict compare keeps the lowest index on a tie.
    always_comb begin
        victim_idx = '0;
        for (int i = 1; i < NUM_ENTRIES; i++) begin
            if (age[i] > age[victim_idx]) victim_idx = IDX_W'(i);
        end
    end

    assign touch = do_write || (exec && op_q == OP_GET && hit_q);
    // A fresh insert has no previous age: treat it as older than everything so all entries age.
    assign old_age = do_insert ? {1'b1, {IDX_W{1'b0}}} : {1'b0, age[wr_idx]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) age[i] <= '0;
        end else if (do_flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) age[i] <= '0;
        end else if (do_clear) begin
            age[hit_idx_q] <= '0;
        end else if (touch) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (IDX_W'(i) == wr_idx)
                    age[i] <= '0;
                else if ({1'b0, age[i]} < old_age && age[i] != '1)
                    age[i] <= age[i] + IDX_W'(1);
            end
        end
    end
`else
    assign victim_idx = '0;
`endif

endmodule

// File: tb/tb_kv_cache_engine.sv
// tb/tb_kv_cache_engine.sv - randomized self-checking bench for kv_cache_engine against a table model
module tb_kv_cache_engine;

    localparam int N  = 16;
    localparam int KW = 16;
    localparam int VW = 64;
    localparam int IW = 4;

    localparam logic [1:0] GET = 2'd0, PUT = 2'd1, DEL = 2'd2, FLUSH = 2'd3;
    localparam logic [1:0] OK = 2'd0, MISS = 2'd1, FULL = 2'd2, EVICTED = 2'd3;
    // Request cycle, LOOKUP, EXEC: resp_valid appears two edges after the accepting edge.
    localparam int RESP_LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'd0;
    logic [KW-1:0] req_key = '0;
    logic [VW-1:0] req_value = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [1:0]    resp_status;
    logic [VW-1:0] resp_value;
    logic [KW-1:0] resp_evict_key;
    logic [IW:0]   used;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    kv_cache_engine #(.NUM_ENTRIES(N), .KEY_WIDTH(KW), .VALUE_WIDTH(VW)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_op_i         (req_op),
        .req_key_i        (req_key),
        .req_value_i      (req_value),
        .resp_valid_o     (resp_valid),
        .resp_ready_i     (resp_ready),
        .resp_status_o    (resp_status),
        .resp_value_o     (resp_value),
        .resp_evict_key_o (resp_evict_key),
        .used_count_o     (used)
    );

    // Reference table: slot contents plus a last-use timestamp for LRU ordering.
    logic [KW-1:0] m_key [N];
    logic [VW-1:0] m_val [N];
    bit            m_valid [N];
    int            m_ts [N];
    int            m_now = 0;

    function automatic void model_clear();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic int model_used();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_valid[i]) c++;
        return c;
    endfunction

    function automatic void model_exec(input logic [1:0] op, input logic [KW-1:0] k, input logic [VW-1:0] v,
                                       output logic [1:0] st, output logic [VW-1:0] rv, output logic [KW-1:0] ek);
        int h = -1;
        int f = -1;
        m_now++;
        st = OK;
        rv = '0;
        ek = '0;
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] && m_key[i] == k) h = i;
            if (!m_valid[i] && f < 0) f = i;
        end
        case (op)
            GET: begin
                if (h >= 0) begin rv = m_val[h]; m_ts[h] = m_now; end
                else st = MISS;
            end
            PUT: begin
                if (h >= 0) begin
                    m_val[h] = v; m_ts[h] = m_now;
                end else if (f >= 0) begin
                    m_valid[f] = 1'b1; m_key[f] = k; m_val[f] = v; m_ts[f] = m_now;
                end else begin : put_full
`ifdef KV_LRU_EVICT_EN
                    int vic = 0;
                    for (int i = 1; i < N; i++) if (m_ts[i] < m_ts[vic]) vic = i;
                    ek = m_key[vic]; m_key[vic] = k; m_val[vic] = v; m_ts[vic] = m_now;
                    st = EVICTED;
`else
                    st = FULL;
`endif
                end
            end
            DEL: begin
                if (h >= 0) m_valid[h] = 1'b0;
                else st = MISS;
            end
            default: model_clear();
        endcase
    endfunction

    task automatic do_req(input logic [1:0] op, input logic [KW-1:0] k, input logic [VW-1:0] v,
                          output logic [1:0] st, output logic [VW-1:0] rv, output logic [KW-1:0] ek,
                          output logic [IW:0] uc, output int lat);
        int n = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL req_ready_wait got 0 want 1");
        end
        req_valid = 1'b1; req_op = op; req_key = k; req_value = v;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 2'($urandom); req_key = 16'($urandom); req_value = {$urandom, $urandom};
        lat = 0;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        if (!resp_valid) begin
            checks++; errors++;
            $display("FAIL resp_valid_wait got 0 want 1");
        end
        st = resp_status; rv = resp_value; ek = resp_evict_key; uc = used;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [1:0] st, es; logic [VW-1:0] rv, ev; logic [KW-1:0] ek, ee; logic [IW:0] uc; int lat;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_status, resp_value, resp_evict_key, used} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%0b vld=%0b st=%0d val=%0h ek=%0h used=%0d want all 0",
                     req_ready, resp_valid, resp_status, resp_value, resp_evict_key, used);
        end
        rst = 1'b0;
        model_clear();
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", req_ready); end
        model_exec(GET, 16'h1234, '0, es, ev, ee);
        do_req(GET, 16'h1234, '0, st, rv, ek, uc, lat);
        checks++;
        if (st !== MISS || rv !== '0 || uc !== '0) begin
            errors++; $display("FAIL reset_get got st=%0d val=%0h used=%0d want st=1 val=0 used=0", st, rv, uc);
        end
    endtask

    task automatic test_basic();
        logic [1:0]  ops [6]   = '{PUT, GET, PUT, GET, DEL, DEL};
        logic [VW-1:0] vals [6] = '{64'hDEAD_BEEF, 64'h0, 64'h5, 64'h0, 64'h0, 64'h0};
        logic [1:0]  exp_st [6] = '{OK, OK, OK, OK, OK, MISS};
        int          exp_uc [6] = '{1, 1, 1, 1, 0, 0};
        logic [1:0] st, es; logic [VW-1:0] rv, ev; logic [KW-1:0] ek, ee; logic [IW:0] uc; int lat;
        for (int i = 0; i < 6; i++) begin
            model_exec(ops[i], 16'h1234, vals[i], es, ev, ee);
            do_req(ops[i], 16'h1234, vals[i], st, rv, ek, uc, lat);
            checks++;
            if (st !== exp_st[i] || rv !== ev || uc !== (IW+1)'(exp_uc[i])) begin
                errors++;
                $display("FAIL basic_%0d got st=%0d val=%0h used=%0d want st=%0d val=%0h used=%0d",
                         i, st, rv, uc, exp_st[i], ev, exp_uc[i]);
            end
            checks++;
            if (lat !== RESP_LAT) begin errors++; $display("FAIL basic_latency_%0d got %0d want %0d", i, lat, RESP_LAT); end
        end
    endtask

    task automatic test_full();
        logic [1:0] st, es; logic [VW-1:0] rv, ev; logic [KW-1:0] ek, ee; logic [IW:0] uc; int lat;
        logic [VW-1:0] v;
        model_exec(FLUSH, '0, '0, es, ev, ee);
        do_req(FLUSH, '0, '0, st, rv, ek, uc, lat);
        checks++;
        if (st !== OK || uc !== '0) begin errors++; $display("FAIL full_flush got st=%0d used=%0d want 0 0", st, uc); end
        for (int k = 0; k < N; k++) begin
            v = {$urandom, $urandom};
            model_exec(PUT, KW'(k), v, es, ev, ee);
            do_req(PUT, KW'(k), v, st, rv, ek, uc, lat);
            checks++;
            if (st !== OK || uc !== (IW+1)'(k + 1)) begin
                errors++; $display("FAIL full_fill_%0d got st=%0d used=%0d want st=0 used=%0d", k, st, uc, k + 1);
            end
        end
        v = {$urandom, $urandom};
        model_exec(PUT, 16'd16, v, es, ev, ee);
        do_req(PUT, 16'd16, v, st, rv, ek, uc, lat);
        checks++;
`ifdef KV_LRU_EVICT_EN
        if (st !== EVICTED || ek !== 16'd0 || uc !== 5'd16) begin
            errors++; $display("FAIL full_put got st=%0d ek=%0h used=%0d want st=3 ek=0 used=16", st, ek, uc);
        end
`else
        if (st !== FULL || ek !== 16'd0 || uc !== 5'd16) begin
            errors++; $display("FAIL full_put got st=%0d ek=%0h used=%0d want st=2 ek=0 used=16", st, ek, uc);
        end
`endif
        model_exec(GET, 16'd16, '0, es, ev, ee);
        do_req(GET, 16'd16, '0, st, rv, ek, uc, lat);
        checks++;
        if (st !== es || rv !== ev) begin
            errors++; $display("FAIL full_get16 got st=%0d val=%0h want st=%0d val=%0h", st, rv, es, ev);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] st, es; logic [VW-1:0] rv, ev; logic [KW-1:0] ek, ee; logic [IW:0] uc; int lat;
        int n = 0;
        model_exec(DEL, 16'd3, '0, es, ev, ee);
        do_req(DEL, 16'd3, '0, st, rv, ek, uc, lat);
        checks++;
        if (st !== es || uc !== (IW+1)'(model_used())) begin
            errors++; $display("FAIL bp_del got st=%0d used=%0d want st=%0d used=%0d", st, uc, es, model_used());
        end
        model_exec(GET, 16'd5, '0, es, ev, ee);
        req_valid = 1'b1; req_op = GET; req_key = 16'd5; req_value = '0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (resp_valid !== 1'b1 || resp_status !== es || resp_value !== ev) begin
            errors++; $display("FAIL bp_first got vld=%0b st=%0d val=%0h want 1 %0d %0h", resp_valid, resp_status, resp_value, es, ev);
        end
        // This PUT is offered while the engine is busy and must never be taken.
        req_valid = 1'b1; req_op = PUT; req_key = 16'h0777; req_value = 64'h77;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_status !== es || resp_value !== ev || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d got vld=%0b st=%0d val=%0h rdy=%0b want 1 %0d %0h 0",
                         c, resp_valid, resp_status, resp_value, req_ready, es, ev);
            end
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got vld=%0b rdy=%0b want 0 1", resp_valid, req_ready);
        end
        model_exec(GET, 16'h0777, '0, es, ev, ee);
        do_req(GET, 16'h0777, '0, st, rv, ek, uc, lat);
        checks++;
        if (st !== es || uc !== (IW+1)'(model_used())) begin
            errors++; $display("FAIL bp_ignored got st=%0d used=%0d want st=%0d used=%0d", st, uc, es, model_used());
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] es; logic [VW-1:0] ev; logic [KW-1:0] ee;
        int nresp = 0;
        int nready = 0;
        resp_ready = 1'b1;
        req_valid = 1'b1; req_op = GET; req_key = 16'd5; req_value = '0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            if (req_ready) nready++;
            if (resp_valid) begin
                nresp++;
                model_exec(GET, 16'd5, '0, es, ev, ee);
                checks++;
                if (resp_status !== es || resp_value !== ev) begin
                    errors++; $display("FAIL b2b_resp_%0d got st=%0d val=%0h want %0d %0h", c, resp_status, resp_value, es, ev);
                end
            end
        end
        req_valid = 1'b0; resp_ready = 1'b0;
        checks++;
        if (nresp != 4 || nready != 4) begin
            errors++; $display("FAIL b2b_rate got resp=%0d ready=%0d want 4 4", nresp, nready);
        end
    endtask

    task automatic test_reset_midop();
        logic [1:0] st, es; logic [VW-1:0] rv, ev; logic [KW-1:0] ek, ee; logic [IW:0] uc; int lat;
        int n = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        req_valid = 1'b1; req_op = PUT; req_key = 16'hBEEF; req_value = {$urandom, $urandom};
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_status, resp_value, resp_evict_key, used} !== '0) begin
            errors++;
            $display("FAIL midop_reset got rdy=%0b vld=%0b st=%0d val=%0h ek=%0h used=%0d want all 0",
                     req_ready, resp_valid, resp_status, resp_value, resp_evict_key, used);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        #1;
        checks++;
        if (req_ready !== 1'b1 || used !== '0) begin
            errors++; $display("FAIL midop_after got rdy=%0b used=%0d want 1 0", req_ready, used);
        end
        model_exec(GET, 16'hBEEF, '0, es, ev, ee);
        do_req(GET, 16'hBEEF, '0, st, rv, ek, uc, lat);
        checks++;
        if (st !== MISS || rv !== '0) begin
            errors++; $display("FAIL midop_get got st=%0d val=%0h want 1 0", st, rv);
        end
    endtask

    task automatic test_random();
        logic [1:0] st, es, op; logic [VW-1:0] rv, ev, v; logic [KW-1:0] ek, ee, k; logic [IW:0] uc; int lat;
        model_exec(FLUSH, '0, '0, es, ev, ee);
        do_req(FLUSH, '0, '0, st, rv, ek, uc, lat);
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 15) == 0) op = FLUSH;
            else op = 2'($urandom_range(0, 2));
`ifdef KV_LRU_EVICT_EN
            if (op == DEL) op = PUT;
`endif
            k = 16'($urandom_range(0, 23));
            v = {$urandom, $urandom};
            model_exec(op, k, v, es, ev, ee);
            do_req(op, k, v, st, rv, ek, uc, lat);
            checks++;
            if (st !== es || rv !== ev || ek !== ee) begin
                errors++;
                $display("FAIL rand_%0d op=%0d key=%0h got st=%0d val=%0h ek=%0h want st=%0d val=%0h ek=%0h",
                         n, op, k, st, rv, ek, es, ev, ee);
            end
            checks++;
            if (uc !== (IW+1)'(model_used())) begin
                errors++; $display("FAIL rand_used_%0d got %0d want %0d", n, uc, model_used());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
